switch_read_ctrl: RTL
=====================

SWITCH_READ_CTRL -- requirements
Module: switch_read_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles needed to accept a confirm-button level change (board builds override it, e.g. 1_000_000).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port io_read  input  1  CPU load request to the switch I/O region.
REQ-005 The block SHALL have port address  input  32  CPU load address.
REQ-006 The block SHALL have port switch_input  input  16  raw board switches, quasi-static.
REQ-007 The block SHALL have port confirm_btn  input  1  raw asynchronous confirm push-button, high = pressed.
REQ-008 The block SHALL have port data_out  output  16  formatted switch word, registered, held until next capture.
REQ-009 The block SHALL have port data_valid  output  1  one-cycle pulse when data_out holds the newly captured value.
REQ-010 The block SHALL have port stall  output  1  holds the CPU while a switch read is outstanding.
REQ-011 The block SHALL have port wait_led  output  1  high while waiting for user confirmation.

Function
REQ-012 Region decode SHALL be: in-region = address[31:4]==28'hffff_fff; mapped = address in {ffff_fff1, ffff_fff3, ffff_fff5, ffff_fff7} or in ffff_fff9..ffff_ffff.
REQ-013 Formatting SHALL be: fff1 -> switch_input[15:0]; fff3 -> sign-extended switch_input[15:8]; fff5 -> {8'b0, switch_input[15:8]}; fff7 -> {13'b0, switch_input[2:0]}; fff9..ffff -> {8'b0, switch_input[7:0]}.
REQ-014 confirm_btn SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Debounced level deb SHALL flip only after the synchronized value has differed from deb for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-016 The FSM SHALL have states IDLE, WAIT_REL, WAIT_PRESS, DONE.
REQ-017 IDLE: on io_read with a mapped address, the block SHALL latch address and go to WAIT_REL; with io_read and an in-region unmapped address (fff0/2/4/6/8) it SHALL go to DONE with data 0; otherwise it SHALL stay in IDLE.
REQ-018 WAIT_REL: the FSM SHALL move to WAIT_PRESS when deb==0 (a press held from a previous read is never reused).
REQ-019 WAIT_PRESS: when deb==1, the FSM SHALL sample switch_input, format it per the latched address, register the result into data_out and go to DONE.
REQ-020 DONE: data_valid SHALL be 1 for exactly this one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-021 stall SHALL be combinational: 1 in the IDLE acceptance cycle (io_read and in-region), 1 in WAIT_REL and WAIT_PRESS, 0 in DONE and otherwise.
REQ-022 wait_led SHALL be 1 exactly in WAIT_REL and WAIT_PRESS.
REQ-023 Latency SHALL be: deb rising in WAIT_PRESS -> data_valid on the next cycle; unmapped read -> data_valid one cycle after acceptance.
REQ-024 io_read and address changes while not in IDLE SHALL be ignored; the latched address governs formatting.
REQ-025 io_read asserted in the DONE cycle SHALL be ignored; a new request is accepted only from IDLE.
REQ-026 Debounce logic SHALL run continuously in every state, independent of the FSM.

Reset
REQ-027 When rst==0 at a posedge, the block SHALL set state=IDLE, data_out=0, data_valid=0, deb=0, debounce counter=0 and synchronizer flops=0; stall=0 and wait_led=0 follow.
REQ-028 A reset mid-wait SHALL abandon the read with no data_valid pulse; the next read starts fresh in WAIT_REL.

Verification
REQ-029 fff1 read, switches 16'hA5C3, button high 4+ cycles -> stall high until DONE, data_out=16'hA5C3, one data_valid pulse.
REQ-030 fff3 with switches 16'h80FF -> 16'hFF80; fff5 -> 16'h0080; fff7 with 16'h000D -> 16'h0005; fffC with 16'h12AB -> 16'h00AB.
REQ-031 Button bouncing 1-0-1-0 every cycle for 20 cycles, then stable high 4 cycles -> no capture during the bounce, capture after the 4th stable cycle plus 2 synchronizer cycles.
REQ-032 Button held high at io_read -> stays in WAIT_REL until release debounced; capture only on the next debounced press.
REQ-033 io_read to ffff_fff4 -> stall only in the acceptance cycle, data_valid next cycle with data_out=0, wait_led stays 0; io_read to 0000_1000 -> no response.
REQ-034 rst low during WAIT_PRESS -> next cycle stall=0, data_out=0, no data_valid; a subsequent fff1 read completes normally.

Source files
------------

// File: rtl/switch_read_ctrl.sv
// Memory-mapped switch read port: decodes CPU loads to the switch region, waits for a
// debounced confirm press, then returns the formatted switch word with a one-cycle valid.
module switch_read_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_read,
    input  logic [31:0] address,
    input  logic [15:0] switch_input,
    input  logic        confirm_btn,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic        wait_led
);

    localparam int DATA_W = 16;
    localparam int CNT_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REL,
        WAIT_PRESS,
        DONE
    } state_t;

    state_t              state;
    state_t              state_d;
    logic                sync_p0;
    logic                sync_p1;
    logic                deb;
    logic [CNT_W-1:0]    deb_cnt;
    logic [3:0]          addr_sel;
    logic                in_region;
    logic                mapped;
    logic                load_sel;
    logic                cap_en;
    logic [DATA_W-1:0]   cap_val;

    // Select the switch field according to the low address nibble of the load.
    function automatic logic [DATA_W-1:0] format_sw(input logic [3:0] sel,
                                                    input logic [DATA_W-1:0] sw);
        logic signed [7:0] hi_s;
        hi_s = $signed(sw[15:8]);
        case (sel)
            4'h1:    format_sw = sw;
            4'h3:    format_sw = DATA_W'(hi_s);
            4'h5:    format_sw = {8'b0, sw[15:8]};
            4'h7:    format_sw = {13'b0, sw[2:0]};
            default: format_sw = {8'b0, sw[7:0]};
        endcase
    endfunction

    assign in_region = (address[31:4] == 28'hfff_ffff);
    assign mapped    = in_region &&
                       ((address[3:0] == 4'h1) || (address[3:0] == 4'h3) ||
                        (address[3:0] == 4'h5) || (address[3:0] == 4'h7) ||
                        (address[3:0] >= 4'h9));

    // Stage p0/p1: two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= confirm_btn;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce runs free of the FSM so the button level is always current.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (sync_p1 != deb) begin
            if (deb_cnt == CNT_LAST) begin
                deb     <= sync_p1;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_sel) begin
            addr_sel <= address[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_d;
            data_valid <= (state_d == DONE);
            if (cap_en) begin
                data_out <= cap_val;
            end
        end
    end

    // WAIT_REL insists on a released button so a press left over from a previous read is not reused.
    always_comb begin
        state_d  = state;
        stall    = 1'b0;
        wait_led = 1'b0;
        load_sel = 1'b0;
        cap_en   = 1'b0;
        cap_val  = '0;
        case (state)
            IDLE: begin
                if (io_read && in_region) begin
                    stall = 1'b1;
                    if (mapped) begin
                        load_sel = 1'b1;
                        state_d  = WAIT_REL;
                    end else begin
                        cap_en  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAIT_REL: begin
                stall    = 1'b1;
                wait_led = 1'b1;
                if (!deb) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                stall    = 1'b1;
                wait_led = 1'b1;
                if (deb) begin
                    cap_en  = 1'b1;
                    cap_val = format_sw(addr_sel, switch_input);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
